cp0_tlb_unit: RTL and testbench

- Parametrised coprocessor-0 register file for the MIPS pipeline: Index, EntryLo0/1, BadVAddr, Count, EntryHi, Compare, Status, Cause, EPC.
- Sits at WB: it commits exceptions, ERET, MTC0, TLBP and TLBR, and serves MFC0 reads.
- Generalises the previous CP0 with a configurable TLB size, Count divider and hardware-interrupt count.
- Adds TLB-exception capture of EntryHi/BadVAddr, a TLBR load path, a registered interrupt request and an exception-entry vector.

---
 rtl/cp0_tlb_unit_pkg.sv | 38 +++
 rtl/cp0_tlb_unit_timer.sv | 47 ++++
 rtl/cp0_tlb_unit.sv | 174 +++++++++++++++++
 tb/tb_cp0_tlb_unit.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_tlb_unit_pkg.sv
// Shared CP0 constants: register numbers, exception codes and exception vectors.
package cp0_tlb_unit_pkg;

  localparam logic [4:0] CP0_INDEX    = 5'd0;
  localparam logic [4:0] CP0_ENTRYLO0 = 5'd2;
  localparam logic [4:0] CP0_ENTRYLO1 = 5'd3;
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_ENTRYHI  = 5'd10;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] VEC_REFILL  = 32'hBFC0_0200;
  localparam logic [31:0] VEC_GENERAL = 32'hBFC0_0380;

  function automatic logic is_tlb_exc(input logic [4:0] code);
    return (code == EXC_MOD) || (code == EXC_TLBL) || (code == EXC_TLBS);
  endfunction

  // Every exception that reports a faulting address to BadVAddr.
  function automatic logic is_addr_exc(input logic [4:0] code);
    return is_tlb_exc(code) || (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_tlb_unit_timer.sv
// CP0 timer: prescaled Count, Compare and the sticky timer-interrupt flag TI.
module cp0_tlb_unit_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic [31:0] count_wdata,
  input  logic        compare_we,
  input  logic [31:0] compare_wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

  logic [DIV_W-1:0] div;

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      compare <= '0;
      div     <= '0;
      ti      <= 1'b0;
    end else begin
      if (count_we) begin
        count <= count_wdata;
        div   <= '0;
      end else if (div == DIV_LAST) begin
        count <= count + 32'd1;
        div   <= '0;
      end else begin
        div <= div + DIV_W'(1);
      end
      // Writing Compare acknowledges the timer interrupt, even on a match cycle.
      if (compare_we) begin
        compare <= compare_wdata;
        ti      <= 1'b0;
      end else if (count == compare) begin
        ti <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_tlb_unit.sv
// Coprocessor-0 register file at WB: exceptions, ERET, MTC0/MFC0, TLBP/TLBR, timer and interrupts.
module cp0_tlb_unit
  import cp0_tlb_unit_pkg::*;
#(
  parameter int TLBNUM     = 16,
  parameter int HW_INT_NUM = 6,
  parameter int COUNT_DIV  = 2,
  parameter int IDX_W      = $clog2(TLBNUM)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4:0]            raddr,
  output logic [31:0]           rdata,
  input  logic                  mtc0_we,
  input  logic [4:0]            mtc0_addr,
  input  logic [31:0]           mtc0_wdata,
  input  logic                  ex_valid,
  input  logic [4:0]            ex_code,
  input  logic                  ex_bd,
  input  logic [31:0]           ex_pc,
  input  logic [31:0]           ex_badvaddr,
  input  logic                  ex_refill,
  input  logic                  eret,
  input  logic [HW_INT_NUM-1:0] hw_int,
  input  logic                  tlbp_we,
  input  logic                  tlbp_found,
  input  logic [IDX_W-1:0]      tlbp_index,
  input  logic                  tlbr_we,
  input  logic [18:0]           tlbr_vpn2,
  input  logic [7:0]            tlbr_asid,
  input  logic                  tlbr_g,
  input  logic [19:0]           tlbr_pfn0,
  input  logic [2:0]            tlbr_c0,
  input  logic                  tlbr_d0,
  input  logic                  tlbr_v0,
  input  logic [19:0]           tlbr_pfn1,
  input  logic [2:0]            tlbr_c1,
  input  logic                  tlbr_d1,
  input  logic                  tlbr_v1,
  output logic [IDX_W-1:0]      tlb_index,
  output logic [31:0]           entryhi,
  output logic [31:0]           entrylo0,
  output logic [31:0]           entrylo1,
  output logic [31:0]           epc,
  output logic                  int_req,
  output logic [31:0]           ex_entry
);

  logic                  idx_p;
  logic [25:0]           lo0_f, lo1_f;
  logic [31:0]           badvaddr;
  logic [18:0]           vpn2;
  logic [7:0]            asid;
  logic [7:0]            im;
  logic                  exl, ie, bd;
  logic [4:0]            exc_code;
  logic [1:0]            ip_sw;
  logic [HW_INT_NUM-1:0] ip_hw;
  logic [5:0]            ip_hi;
  logic [7:0]            ip;
  logic [31:0]           count, compare;
  logic                  ti;
  logic                  tlb_ok, mtc0_go;

  // Lower-priority commits are dropped whenever a higher-priority one is present.
  assign tlb_ok  = !ex_valid && !eret;
  assign mtc0_go = mtc0_we && tlb_ok && !tlbp_we && !tlbr_we;

  cp0_tlb_unit_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk           (clk),
    .reset         (reset),
    .count_we      (mtc0_go && mtc0_addr == CP0_COUNT),
    .count_wdata   (mtc0_wdata),
    .compare_we    (mtc0_go && mtc0_addr == CP0_COMPARE),
    .compare_wdata (mtc0_wdata),
    .count         (count),
    .compare       (compare),
    .ti            (ti)
  );

  // Unused hardware-interrupt slots read as zero; IP[7] also carries the timer.
  assign ip_hi = 6'(ip_hw);
  assign ip    = {ip_hi[5] | ti, ip_hi[4:0], ip_sw};

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_p     <= 1'b0;
      tlb_index <= '0;
      lo0_f     <= '0;
      lo1_f     <= '0;
      badvaddr  <= '0;
      vpn2      <= '0;
      asid      <= '0;
      im        <= '0;
      exl       <= 1'b0;
      ie        <= 1'b0;
      bd        <= 1'b0;
      exc_code  <= '0;
      ip_sw     <= '0;
      ip_hw     <= '0;
      epc       <= '0;
      int_req   <= 1'b0;
    end else begin
      ip_hw   <= hw_int;
      int_req <= ie && !exl && ((ip & im) != 8'd0);
      if (ex_valid) begin
        exc_code <= ex_code;
        exl      <= 1'b1;
        if (!exl) begin
          epc <= ex_bd ? ex_pc - 32'd4 : ex_pc;
          bd  <= ex_bd;
        end
        if (is_addr_exc(ex_code)) badvaddr <= ex_badvaddr;
        if (is_tlb_exc(ex_code))  vpn2     <= ex_badvaddr[31:13];
      end else if (eret) begin
        exl <= 1'b0;
      end else if (tlbp_we || tlbr_we) begin
        if (tlbp_we) begin
          idx_p <= !tlbp_found;
          if (tlbp_found) tlb_index <= tlbp_index;
        end
        if (tlbr_we) begin
          vpn2  <= tlbr_vpn2;
          asid  <= tlbr_asid;
          lo0_f <= {tlbr_pfn0, tlbr_c0, tlbr_d0, tlbr_v0, tlbr_g};
          lo1_f <= {tlbr_pfn1, tlbr_c1, tlbr_d1, tlbr_v1, tlbr_g};
        end
      end else if (mtc0_go) begin
        case (mtc0_addr)
          CP0_INDEX:    tlb_index <= mtc0_wdata[IDX_W-1:0];
          CP0_ENTRYLO0: lo0_f     <= mtc0_wdata[25:0];
          CP0_ENTRYLO1: lo1_f     <= mtc0_wdata[25:0];
          CP0_ENTRYHI: begin
            vpn2 <= mtc0_wdata[31:13];
            asid <= mtc0_wdata[7:0];
          end
          CP0_STATUS: begin
            im  <= mtc0_wdata[15:8];
            exl <= mtc0_wdata[1];
            ie  <= mtc0_wdata[0];
          end
          CP0_CAUSE: ip_sw <= mtc0_wdata[9:8];
          CP0_EPC:   epc   <= mtc0_wdata;
          default: ;
        endcase
      end
    end
  end

  assign entryhi  = {vpn2, 5'b0, asid};
  assign entrylo0 = {6'b0, lo0_f};
  assign entrylo1 = {6'b0, lo1_f};

  assign ex_entry = (ex_refill && !exl && (ex_code == EXC_TLBL || ex_code == EXC_TLBS))
                    ? VEC_REFILL : VEC_GENERAL;

  always_comb begin
    rdata = 32'h0;
    case (raddr)
      CP0_INDEX:    rdata = {idx_p, {(31 - IDX_W){1'b0}}, tlb_index};
      CP0_ENTRYLO0: rdata = entrylo0;
      CP0_ENTRYLO1: rdata = entrylo1;
      CP0_BADVADDR: rdata = badvaddr;
      CP0_COUNT:    rdata = count;
      CP0_ENTRYHI:  rdata = entryhi;
      CP0_COMPARE:  rdata = compare;
      CP0_STATUS:   rdata = {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
      CP0_CAUSE:    rdata = {bd, ti, 14'b0, ip, 1'b0, exc_code, 2'b0};
      CP0_EPC:      rdata = epc;
      default:      rdata = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_cp0_tlb_unit.sv
// Randomized and directed bench for cp0_tlb_unit against a word-level CP0 reference model.
module tb_cp0_tlb_unit;

  localparam int TLBNUM = 16, HW_INT_NUM = 6, COUNT_DIV = 2, IDX_W = 4;

  logic clk;
  logic reset;
  logic [4:0] raddr;
  logic [31:0] rdata;
  logic mtc0_we;
  logic [4:0] mtc0_addr;
  logic [31:0] mtc0_wdata;
  logic ex_valid, ex_bd, ex_refill, eret;
  logic [4:0] ex_code;
  logic [31:0] ex_pc, ex_badvaddr;
  logic [HW_INT_NUM-1:0] hw_int;
  logic tlbp_we, tlbp_found, tlbr_we, tlbr_g;
  logic [IDX_W-1:0] tlbp_index, tlb_index;
  logic [18:0] tlbr_vpn2;
  logic [7:0] tlbr_asid;
  logic [19:0] tlbr_pfn0, tlbr_pfn1;
  logic [2:0] tlbr_c0, tlbr_c1;
  logic tlbr_d0, tlbr_v0, tlbr_d1, tlbr_v1;
  logic [31:0] entryhi, entrylo0, entrylo1, epc, ex_entry;
  logic int_req;

  int n_cmp, n_bad;

  cp0_tlb_unit #(.TLBNUM(TLBNUM), .HW_INT_NUM(HW_INT_NUM), .COUNT_DIV(COUNT_DIV)) dut (
    .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata),
    .mtc0_we(mtc0_we), .mtc0_addr(mtc0_addr), .mtc0_wdata(mtc0_wdata),
    .ex_valid(ex_valid), .ex_code(ex_code), .ex_bd(ex_bd), .ex_pc(ex_pc),
    .ex_badvaddr(ex_badvaddr), .ex_refill(ex_refill), .eret(eret), .hw_int(hw_int),
    .tlbp_we(tlbp_we), .tlbp_found(tlbp_found), .tlbp_index(tlbp_index),
    .tlbr_we(tlbr_we), .tlbr_vpn2(tlbr_vpn2), .tlbr_asid(tlbr_asid), .tlbr_g(tlbr_g),
    .tlbr_pfn0(tlbr_pfn0), .tlbr_c0(tlbr_c0), .tlbr_d0(tlbr_d0), .tlbr_v0(tlbr_v0),
    .tlbr_pfn1(tlbr_pfn1), .tlbr_c1(tlbr_c1), .tlbr_d1(tlbr_d1), .tlbr_v1(tlbr_v1),
    .tlb_index(tlb_index), .entryhi(entryhi), .entrylo0(entrylo0), .entrylo1(entrylo1),
    .epc(epc), .int_req(int_req), .ex_entry(ex_entry)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Reference model: architectural register words plus a few Cause fields.
  logic [31:0] m_index, m_lo0, m_lo1, m_badv, m_count, m_hi, m_compare, m_status, m_epc;
  logic m_bd, m_ti, m_int;
  logic [4:0] m_exc;
  logic [1:0] m_ip_sw;
  logic [5:0] m_ip_hw;
  int m_div;

  function automatic logic [7:0] m_ip();
    return {m_ip_hw[5] | m_ti, m_ip_hw[4:0], m_ip_sw};
  endfunction

  function automatic logic [31:0] m_cause();
    return {m_bd, m_ti, 14'b0, m_ip(), 1'b0, m_exc, 2'b0};
  endfunction

  function automatic logic [31:0] exp_reg(input logic [4:0] r);
    case (r)
      5'd0:  return m_index;
      5'd2:  return m_lo0;
      5'd3:  return m_lo1;
      5'd8:  return m_badv;
      5'd9:  return m_count;
      5'd10: return m_hi;
      5'd11: return m_compare;
      5'd12: return m_status;
      5'd13: return m_cause();
      5'd14: return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] exp_entry();
    return (ex_refill && !m_status[1] && (ex_code == 5'd2 || ex_code == 5'd3))
           ? 32'hBFC0_0200 : 32'hBFC0_0380;
  endfunction

  task automatic model_reset();
    m_index = 0; m_lo0 = 0; m_lo1 = 0; m_badv = 0; m_count = 0; m_hi = 0;
    m_compare = 0; m_status = 32'h0040_0000; m_epc = 0;
    m_bd = 0; m_ti = 0; m_int = 0; m_exc = 0; m_ip_sw = 0; m_ip_hw = 0; m_div = 0;
  endtask

  task automatic model_step();
    logic mtc;
    logic [31:0] w;
    if (reset) begin
      model_reset();
      return;
    end
    mtc = mtc0_we && !ex_valid && !eret && !tlbp_we && !tlbr_we;
    w = mtc0_wdata;
    m_int = m_status[0] && !m_status[1] && ((m_ip() & m_status[15:8]) != 0);
    if (mtc && mtc0_addr == 5'd11) m_ti = 0;
    else if (m_count == m_compare) m_ti = 1;
    if (mtc && mtc0_addr == 5'd11) m_compare = w;
    if (mtc && mtc0_addr == 5'd9) begin
      m_count = w; m_div = 0;
    end else if (m_div == COUNT_DIV - 1) begin
      m_count = m_count + 1; m_div = 0;
    end else m_div = m_div + 1;
    m_ip_hw = hw_int;
    if (ex_valid) begin
      m_exc = ex_code;
      if (!m_status[1]) begin
        m_epc = ex_bd ? ex_pc - 4 : ex_pc;
        m_bd = ex_bd;
      end
      m_status[1] = 1;
      if (ex_code inside {5'd1, 5'd2, 5'd3, 5'd4, 5'd5}) m_badv = ex_badvaddr;
      if (ex_code inside {5'd1, 5'd2, 5'd3}) m_hi[31:13] = ex_badvaddr[31:13];
    end else if (eret) begin
      m_status[1] = 0;
    end else if (tlbp_we || tlbr_we) begin
      if (tlbp_we) begin
        m_index[31] = !tlbp_found;
        if (tlbp_found) m_index[3:0] = tlbp_index;
      end
      if (tlbr_we) begin
        m_hi  = {tlbr_vpn2, 5'b0, tlbr_asid};
        m_lo0 = {6'b0, tlbr_pfn0, tlbr_c0, tlbr_d0, tlbr_v0, tlbr_g};
        m_lo1 = {6'b0, tlbr_pfn1, tlbr_c1, tlbr_d1, tlbr_v1, tlbr_g};
      end
    end else if (mtc) begin
      case (mtc0_addr)
        5'd0:  m_index = (m_index & ~32'hF) | (w & 32'hF);
        5'd2:  m_lo0 = w & 32'h03FF_FFFF;
        5'd3:  m_lo1 = w & 32'h03FF_FFFF;
        5'd10: m_hi = w & 32'hFFFF_E0FF;
        5'd12: m_status = 32'h0040_0000 | (w & 32'h0000_FF03);
        5'd13: m_ip_sw = w[9:8];
        5'd14: m_epc = w;
        default: ;
      endcase
    end
  endtask

  task automatic idle();
    mtc0_we = 0; mtc0_addr = 0; mtc0_wdata = 0;
    ex_valid = 0; ex_code = 0; ex_bd = 0; ex_pc = 0; ex_badvaddr = 0; ex_refill = 0;
    eret = 0; hw_int = 0; tlbp_we = 0; tlbp_found = 0; tlbp_index = 0;
    tlbr_we = 0; tlbr_vpn2 = 0; tlbr_asid = 0; tlbr_g = 0;
    tlbr_pfn0 = 0; tlbr_c0 = 0; tlbr_d0 = 0; tlbr_v0 = 0;
    tlbr_pfn1 = 0; tlbr_c1 = 0; tlbr_d1 = 0; tlbr_v1 = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle(); reset = 1; cycle(); reset = 0;
  endtask

  task automatic do_mtc0(input logic [4:0] a, input logic [31:0] d);
    mtc0_we = 1; mtc0_addr = a; mtc0_wdata = d;
    cycle();
    mtc0_we = 0;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    do_reset();
    for (int r = 0; r < 16; r++) begin
      raddr = 5'(r); #1;
      e = (r == 12) ? 32'h0040_0000 : 32'h0;
      n_cmp++;
      if (rdata !== e) begin n_bad++; $display("FAIL reset_reg%0d got=%h exp=%h", r, rdata, e); end
    end
    n_cmp++;
    if (int_req !== 1'b0) begin n_bad++; $display("FAIL reset_int_req got=%b exp=0", int_req); end
    n_cmp++;
    if (ex_entry !== 32'hBFC0_0380) begin n_bad++; $display("FAIL reset_ex_entry got=%h exp=bfc00380", ex_entry); end
  endtask

  task automatic test_timer();
    do_reset();
    do_mtc0(5'd11, 32'd10);
    do_mtc0(5'd12, 32'h0000_8001);
    for (int e = 3; e <= 24; e++) begin
      cycle();
      raddr = 5'd9; #1;
      n_cmp++;
      if (rdata !== m_count) begin n_bad++; $display("FAIL timer_count e=%0d got=%h exp=%h", e, rdata, m_count); end
      raddr = 5'd13; #1;
      n_cmp++;
      if (rdata !== m_cause()) begin n_bad++; $display("FAIL timer_cause e=%0d got=%h exp=%h", e, rdata, m_cause()); end
      if (e == 20 || e == 21) begin
        n_cmp++;
        if (rdata[30] !== (e == 21)) begin n_bad++; $display("FAIL timer_ti e=%0d got=%b", e, rdata[30]); end
      end
      if (e == 21 || e == 22) begin
        n_cmp++;
        if (int_req !== (e == 22)) begin n_bad++; $display("FAIL timer_int e=%0d got=%b", e, int_req); end
      end
      n_cmp++;
      if (int_req !== m_int) begin n_bad++; $display("FAIL timer_int_model e=%0d got=%b exp=%b", e, int_req, m_int); end
    end
    do_mtc0(5'd11, 32'd1000);
    raddr = 5'd13; #1;
    n_cmp++;
    if (rdata[30] !== 1'b0) begin n_bad++; $display("FAIL timer_ti_clear got=%b exp=0", rdata[30]); end
  endtask

  task automatic test_exception();
    do_reset();
    ex_valid = 1; ex_code = 5'd2; ex_bd = 1; ex_pc = 32'h8000_1004;
    ex_badvaddr = 32'h0040_2ABC; ex_refill = 1; #1;
    n_cmp++;
    if (ex_entry !== 32'hBFC0_0200) begin n_bad++; $display("FAIL exc_entry_refill got=%h exp=bfc00200", ex_entry); end
    cycle(); idle();
    n_cmp++;
    if (epc !== 32'h8000_1000) begin n_bad++; $display("FAIL exc_epc got=%h exp=80001000", epc); end
    raddr = 5'd13; #1;
    n_cmp++;
    if (rdata[31] !== 1'b1 || rdata[6:2] !== 5'd2) begin n_bad++; $display("FAIL exc_cause got=%h exp bd=1 code=2", rdata); end
    raddr = 5'd8; #1;
    n_cmp++;
    if (rdata !== 32'h0040_2ABC) begin n_bad++; $display("FAIL exc_badvaddr got=%h exp=00402abc", rdata); end
    n_cmp++;
    if (entryhi[31:13] !== 19'h00201) begin n_bad++; $display("FAIL exc_vpn2 got=%h exp=00201", entryhi[31:13]); end
    ex_valid = 1; ex_code = 5'd3; ex_bd = 0; ex_pc = 32'h8000_2000; ex_refill = 1; #1;
    n_cmp++;
    if (ex_entry !== 32'hBFC0_0380) begin n_bad++; $display("FAIL exc_entry_exl got=%h exp=bfc00380", ex_entry); end
    cycle(); idle();
    raddr = 5'd13; #1;
    n_cmp++;
    if (epc !== 32'h8000_1000 || rdata[6:2] !== 5'd3) begin n_bad++; $display("FAIL exc_nested epc=%h cause=%h exp epc=80001000 code=3", epc, rdata); end
    eret = 1; cycle(); idle();
    raddr = 5'd12; #1;
    n_cmp++;
    if (rdata !== 32'h0040_0000) begin n_bad++; $display("FAIL eret_status got=%h exp=00400000", rdata); end
  endtask

  task automatic test_tlb();
    do_reset();
    tlbp_we = 1; tlbp_found = 0; tlbp_index = 4'd7; cycle(); idle();
    raddr = 5'd0; #1;
    n_cmp++;
    if (rdata !== 32'h8000_0000) begin n_bad++; $display("FAIL tlbp_miss got=%h exp=80000000", rdata); end
    tlbp_we = 1; tlbp_found = 1; tlbp_index = 4'd5; cycle(); idle();
    #1;
    n_cmp++;
    if (rdata !== 32'h0000_0005 || tlb_index !== 4'd5) begin n_bad++; $display("FAIL tlbp_hit got=%h/%h exp=5", rdata, tlb_index); end
    tlbr_we = 1; tlbr_vpn2 = 19'h1234; tlbr_asid = 8'h5A; tlbr_g = 1;
    tlbr_pfn0 = 20'hABCDE; tlbr_c0 = 3'd3; tlbr_d0 = 1; tlbr_v0 = 1;
    tlbr_pfn1 = 20'h13579; tlbr_c1 = 3'd2; tlbr_d1 = 0; tlbr_v1 = 1;
    cycle(); idle();
    n_cmp++;
    if (entryhi !== 32'h0246_805A) begin n_bad++; $display("FAIL tlbr_hi got=%h exp=0246805a", entryhi); end
    n_cmp++;
    if (entrylo0 !== 32'h02AF_379F) begin n_bad++; $display("FAIL tlbr_lo0 got=%h exp=02af379f", entrylo0); end
    n_cmp++;
    if (entrylo1 !== m_lo1) begin n_bad++; $display("FAIL tlbr_lo1 got=%h exp=%h", entrylo1, m_lo1); end
  endtask

  task automatic test_priority();
    do_reset();
    ex_valid = 1; ex_code = 5'd12; ex_pc = 32'h8000_3000;
    mtc0_we = 1; mtc0_addr = 5'd14; mtc0_wdata = 32'h1234_5678;
    cycle(); idle();
    n_cmp++;
    if (epc !== 32'h8000_3000) begin n_bad++; $display("FAIL prio_epc got=%h exp=80003000", epc); end
    do_mtc0(5'd9, 32'hFFFF_FFFF);
    raddr = 5'd9; #1;
    n_cmp++;
    if (rdata !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL count_load got=%h exp=ffffffff", rdata); end
    cycle(); cycle(); #1;
    n_cmp++;
    if (rdata !== 32'h0) begin n_bad++; $display("FAIL count_wrap got=%h exp=0", rdata); end
  endtask

  task automatic test_hw_int();
    do_reset();
    do_mtc0(5'd12, 32'h0000_0401);
    hw_int = 6'b000001;
    cycle();
    raddr = 5'd13; #1;
    n_cmp++;
    if (rdata[10] !== 1'b1 || int_req !== 1'b0) begin n_bad++; $display("FAIL hwint_ip cause=%h int=%b exp ip2=1 int=0", rdata, int_req); end
    cycle();
    n_cmp++;
    if (int_req !== 1'b1) begin n_bad++; $display("FAIL hwint_req got=%b exp=1", int_req); end
    hw_int = 0;
  endtask

  task automatic test_random(input int ncyc);
    logic [4:0] codes [10];
    logic [31:0] e;
    codes = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12};
    for (int c = 0; c < ncyc; c++) begin
      idle();
      reset       = ($urandom_range(0, 149) == 0);
      hw_int      = 6'($urandom);
      ex_valid    = ($urandom_range(0, 9) == 0);
      ex_code     = codes[$urandom_range(0, 9)];
      ex_bd       = 1'($urandom);
      ex_pc       = $urandom;
      ex_badvaddr = $urandom;
      ex_refill   = 1'($urandom);
      eret        = ($urandom_range(0, 11) == 0);
      tlbp_we     = ($urandom_range(0, 9) == 0);
      tlbp_found  = 1'($urandom);
      tlbp_index  = 4'($urandom);
      tlbr_we     = ($urandom_range(0, 9) == 0);
      {tlbr_vpn2, tlbr_asid, tlbr_g} = 28'($urandom);
      {tlbr_pfn0, tlbr_c0, tlbr_d0, tlbr_v0} = 25'($urandom);
      {tlbr_pfn1, tlbr_c1, tlbr_d1, tlbr_v1} = 25'($urandom);
      mtc0_we     = ($urandom_range(0, 2) == 0);
      mtc0_addr   = 5'($urandom);
      mtc0_wdata  = (mtc0_addr == 5'd11) ? m_count + $urandom_range(0, 6) : $urandom;
      #1;
      n_cmp++;
      if (ex_entry !== exp_entry()) begin n_bad++; $display("FAIL rnd_ex_entry c=%0d got=%h exp=%h", c, ex_entry, exp_entry()); end
      cycle();
      for (int r = 0; r < 16; r++) begin
        raddr = 5'(r); #1;
        e = exp_reg(5'(r));
        n_cmp++;
        if (rdata !== e) begin n_bad++; $display("FAIL rnd_reg%0d c=%0d got=%h exp=%h", r, c, rdata, e); end
      end
      n_cmp++;
      if ({tlb_index, entryhi, entrylo0, entrylo1, epc, int_req} !==
          {m_index[3:0], m_hi, m_lo0, m_lo1, m_epc, m_int}) begin
        n_bad++;
        $display("FAIL rnd_outputs c=%0d idx=%h hi=%h lo0=%h lo1=%h epc=%h int=%b exp %h %h %h %h %h %b",
                 c, tlb_index, entryhi, entrylo0, entrylo1, epc, int_req,
                 m_index[3:0], m_hi, m_lo0, m_lo1, m_epc, m_int);
      end
    end
    reset = 0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] e;
    test_random(20);
    do_mtc0(5'd14, 32'hDEAD_BEEF);
    do_mtc0(5'd12, 32'h0000_FF03);
    do_reset();
    for (int r = 0; r < 16; r++) begin
      raddr = 5'(r); #1;
      e = (r == 12) ? 32'h0040_0000 : 32'h0;
      n_cmp++;
      if (rdata !== e) begin n_bad++; $display("FAIL midreset_reg%0d got=%h exp=%h", r, rdata, e); end
    end
    n_cmp++;
    if (int_req !== 1'b0 || epc !== 32'h0) begin n_bad++; $display("FAIL midreset_out int=%b epc=%h exp 0", int_req, epc); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    raddr = 0; reset = 1;
    idle();
    model_reset();
    @(negedge clk);
    test_reset();
    test_timer();
    test_exception();
    test_tlb();
    test_priority();
    test_hw_int();
    do_reset();
    test_random(400);
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
